// File: rtl/bcd_counter_display_pkg.sv
// Shared constants for the BCD counter/display: active-low segment patterns
// (bit order gfedcba) and the BCD digit width.
package bcd_counter_display_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_counter_display_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show 0.
module seg7_decode
    import bcd_counter_display_pkg::*;
(
    input  logic [BCD_W-1:0] code_i,
    output logic [6:0]       segs_o
);

    always_comb begin
        case (code_i)
            4'd0:    segs_o = SEG_0;
            4'd1:    segs_o = SEG_1;
            4'd2:    segs_o = SEG_2;
            4'd3:    segs_o = SEG_3;
            4'd4:    segs_o = SEG_4;
            4'd5:    segs_o = SEG_5;
            4'd6:    segs_o = SEG_6;
            4'd7:    segs_o = SEG_7;
            4'd8:    segs_o = SEG_8;
            4'd9:    segs_o = SEG_9;
            default: segs_o = SEG_0;
        endcase
    end

endmodule

// File: rtl/bcd_counter_display.sv
// Up/down BCD counter with load, wrap pulse and registered 7-segment outputs.
// Define BCD_LEADING_ZERO_BLANK_EN to blank zero digits above the leading nonzero digit.
module bcd_counter_display
    import bcd_counter_display_pkg::*;
#(
    parameter int                      DIGITS  = 4,
    parameter logic [BCD_W*DIGITS-1:0] MAX_VAL = '0
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   load_val,
    output logic [BCD_W*DIGITS-1:0]   count,
    output logic                      carry,
    output logic [7*DIGITS-1:0]       segs
);

    localparam int W = BCD_W * DIGITS;
    localparam logic [W-1:0] TERM = (MAX_VAL != '0) ? MAX_VAL : {DIGITS{4'h9}};

    function automatic logic [7*DIGITS-1:0] reset_display();
        logic [7*DIGITS-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
            r[k*7 +: 7] = (k == 0) ? SEG_0 : SEG_BLANK;
`else
            r[k*7 +: 7] = SEG_0;
`endif
        end
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] SEGS_RST = reset_display();

    logic [W-1:0]        count_q, count_d;
    logic                carry_q, carry_d;
    logic [7*DIGITS-1:0] segs_q, segs_d;
    logic [W-1:0]        load_clean, inc_val, dec_val;
    logic                inc_c, dec_b;
    logic [7*DIGITS-1:0] dec_raw;

    // Invalid digits load as 0; values beyond a custom terminal count load as 0.
    always_comb begin
        load_clean = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_clean[k*BCD_W +: BCD_W] = (load_val[k*BCD_W +: BCD_W] > 4'd9)
                                         ? 4'd0 : load_val[k*BCD_W +: BCD_W];
        end
        if ((MAX_VAL != '0) && (load_clean > MAX_VAL)) begin
            load_clean = '0;
        end
    end

    always_comb begin
        inc_val = count_q;
        dec_val = count_q;
        inc_c   = 1'b1;
        dec_b   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (inc_c) begin
                if (count_q[k*BCD_W +: BCD_W] == 4'd9) begin
                    inc_val[k*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    inc_val[k*BCD_W +: BCD_W] = count_q[k*BCD_W +: BCD_W] + 4'd1;
                    inc_c = 1'b0;
                end
            end
            if (dec_b) begin
                if (count_q[k*BCD_W +: BCD_W] == 4'd0) begin
                    dec_val[k*BCD_W +: BCD_W] = 4'd9;
                end else begin
                    dec_val[k*BCD_W +: BCD_W] = count_q[k*BCD_W +: BCD_W] - 4'd1;
                    dec_b = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (load) begin
            count_d = load_clean;
        end else if (en) begin
            if (up) begin
                if (count_q == TERM) begin
                    count_d = '0;
                    carry_d = 1'b1;
                end else begin
                    count_d = inc_val;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = TERM;
                    carry_d = 1'b1;
                end else begin
                    count_d = dec_val;
                end
            end
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        seg7_decode u_dec (
            .code_i (count_q[k*BCD_W +: BCD_W]),
            .segs_o (dec_raw[k*7 +: 7])
        );
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic lead_zero;
    // Walk down from the top digit; digit 0 is never blanked.
    always_comb begin
        segs_d    = dec_raw;
        lead_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (count_q[k*BCD_W +: BCD_W] != 4'd0) begin
                lead_zero = 1'b0;
            end
            if (lead_zero) begin
                segs_d[k*7 +: 7] = SEG_BLANK;
            end
        end
    end
`else
    assign segs_d = dec_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            carry_q <= 1'b0;
            segs_q  <= SEGS_RST;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            segs_q  <= segs_d;
        end
    end

    assign count = count_q;
    assign carry = carry_q;
    assign segs  = segs_q;

endmodule

// File: doc/bcd_counter_display.md
BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

Interface
REQ-001 Parameter DIGITS, default 4, meaning number of BCD digits counted and displayed (range 1..8).
REQ-002 Parameter MAX_VAL, default 0 (disabled), meaning terminal count as a 4*DIGITS-bit BCD word; when nonzero the counter wraps at MAX_VAL instead of all-nines.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  count-enable strobe; one step per cycle while high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load request.
REQ-008 load_val  input  4*DIGITS  BCD value to load; digit k at bits [4k+3:4k].
REQ-009 count  output  4*DIGITS  registered BCD count, digit 0 least significant.
REQ-010 carry  output  1  registered one-cycle wrap pulse (carry on up, borrow on down).
REQ-011 segs  output  7*DIGITS  registered active-low segment patterns, digit k at [7k+6:7k], bit order gfedcba.

Function
REQ-012 Priority per cycle SHALL be rst > load > en; with none asserted all registers hold.
REQ-013 load SHALL write load_val to count next cycle, replacing any digit >9 with 0; if MAX_VAL nonzero and loaded value > MAX_VAL, count SHALL become 0; carry SHALL be 0 that cycle.
REQ-014 en with up=1 SHALL increment by 1 in decimal: digit 9 -> 0 with carry into next digit; others +1.
REQ-015 en with up=0 SHALL decrement by 1 in decimal: digit 0 -> 9 with borrow from next digit; others -1.
REQ-016 Up-wrap: at terminal count (all nines, or MAX_VAL if nonzero) increment SHALL give 0 and set carry=1 for exactly the cycle in which count shows 0.
REQ-017 Down-wrap: at 0, decrement SHALL give terminal count and set carry=1 for exactly the cycle in which the terminal count appears.
REQ-018 carry SHALL be 0 in every cycle not covered by REQ-016/REQ-017, including consecutive non-wrapping steps.
REQ-019 segs SHALL reflect count with one cycle latency (segs at cycle n+1 = decode(count at cycle n)).
REQ-020 Decode SHALL be 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000 8:0000000 9:0010000; any other code SHALL decode as 1000000.
REQ-021 Changing up mid-sequence SHALL take effect on the next en cycle with no lost or extra step.

Reset
REQ-022 rst SHALL set count=0, carry=0 and segs to the reset display (all digits 1000000, or per REQ-024), overriding load and en in the same cycle, including mid-wrap.
REQ-023 First count step after rst deassertion SHALL occur on the first cycle with en=1 and rst=0.

Configuration
REQ-024 With macro BCD_LEADING_ZERO_BLANK_EN defined, every zero digit above the most significant nonzero digit SHALL drive 1111111 (digit 0 always shown, so value 0 shows a single 0); without it all digits SHALL always be decoded per REQ-020.

Structure
REQ-025 A shared package SHALL hold the ten segment-pattern constants, the blank pattern 1111111 and the BCD digit width constant 4.
REQ-026 One sub-module seg7_decode (4-bit code in, 7-bit active-low pattern out, combinational) SHALL be instantiated DIGITS times.

Verification (DIGITS=4, MAX_VAL=0 unless stated)
REQ-027 rst=1 with load=1, en=1 -> next cycle count=0000, carry=0, segs all 1000000 (macro off).
REQ-028 load 9998, then en=1 up=1 for 2 cycles -> count 9999 then 0000 with carry=1 only on 0000; segs lag count by one cycle.
REQ-029 load 0000, en=1 up=0 -> count 9999, carry=1 one cycle; next step 9998, carry=0.
REQ-030 load_val 0x1A3F -> count 1030; with MAX_VAL=0x0059, load 0x0060 -> count 0000; count 0059 up -> 0000 carry=1.
REQ-031 Macro on, count 0042 -> segs digits 3..2 = 1111111, digit 1 = 0011001, digit 0 = 0100100; count 0000 -> only digit 0 shows 1000000.
REQ-032 load=1 and en=1 same cycle at count 0005, load_val 0300 -> count 0300, carry=0.
